adder16_sched: RTL
==================

// Module: adder16_sched
// PURPOSE
//   Shares one combinational adder16 (a, b -> s, no carry in or out) between NREQ requesters.
//   Typical requesters are the ALU (ADDA/SUBA/ADDL/SUBL), effective-address calculation and PC increment.
//   Arbitrates round-robin, sequences subtraction as two adder passes (negate, then add) and returns sum plus OF/SF/ZF/CF.
//   Sits between the COMET2 control unit and the single adder16 instance in the ALU.
// PARAMETERS
//   W     16  datapath width (adder16 is fixed at 16; other values unsupported)
//   NREQ  3   number of requesters (2..4)
// PORTS
//   clk        in   1       clock, all state on rising edge
//   rst_n      in   1       synchronous active-low reset
//   req_valid  in   NREQ    requester i has an operation pending
//   req_sub    in   NREQ    1 = a-b, 0 = a+b (per requester)
//   req_a      in   NREQ*W  operand a, requester i at [i*W +: W]
//   req_b      in   NREQ*W  operand b, requester i at [i*W +: W]
//   req_ready  out  NREQ    one-hot grant; handshake = valid&ready at clock edge
//   resp_valid out  1       one-cycle result pulse, no backpressure
//   resp_id    out  2       index of requester the result belongs to
//   resp_sum   out  W       result
//   resp_of    out  1       signed overflow
//   resp_sf    out  1       resp_sum[W-1]
//   resp_zf    out  1       resp_sum == 0
//   resp_cf    out  1       add: unsigned carry out; sub: borrow (a < b unsigned)
//   add_a      out  W       to adder16 .a
//   add_b      out  W       to adder16 .b
//   add_s      in   W       from adder16 .s
// BEHAVIOUR
//   Reset (rst_n=0 at edge):
//     state=IDLE, last-grant pointer=NREQ-1, resp_valid=0, resp_id/sum/flags=0, latched operands=0.
//   Reset mid-operation aborts the operation; no resp_valid is produced for it.
//   States IDLE, NEG, ADD.
//   IDLE:
//     add_a=add_b=0.
//     If any req_valid, req_ready asserts combinationally for the winner only.
//     Winner = first valid scanning from (last+1) mod NREQ upward.
//     At the edge: capture a, b, sub and id; last<=winner.
//     Next state is NEG if sub, else ADD. If no req_valid, req_ready=0 and stay in IDLE.
//   NEG (sub only):
//     add_a=~b, add_b=1.
//     At the edge: tmp<=add_s; go to ADD.
//   ADD:
//     add_a=a, add_b = sub ? tmp : b.
//     At the edge: resp_sum<=add_s, flags, id; resp_valid<=1; go to IDLE.
//   req_ready is 0 outside IDLE. resp_valid is 0 on every cycle except the one after ADD.
//   Latency from the handshake edge to resp_valid high: add 2 cycles, sub 3 cycles.
//   Peak throughput: one add every 2 cycles. IDLE may grant in the same cycle that resp_valid is high.
//   Flags use the captured a/b (not tmp), s = add_s:
//     add: cf = (s < a) unsigned; of = (a[W-1]==b[W-1]) & (s[W-1]!=a[W-1])
//     sub: cf = (a < b) unsigned; of = (a[W-1]!=b[W-1]) & (s[W-1]!=a[W-1])
//   All sums wrap modulo 2^W.
//   Sub with b=0: the negate pass wraps to 0, result=a, cf=0, of=0.
//   Sub with b=0x8000: the negate pass gives 0x8000; the flag rules above still hold.
//   A requester that drops req_valid before its grant loses nothing (no state is kept for it).
//   Operand changes after the handshake are ignored.
// TESTING
//   1. Req0 add 0xFFFF+0x0001 -> resp_valid 2 cycles after handshake; sum=0x0000, zf=1, cf=1, of=0, sf=0, id=0.
//   2. Req1 sub 10000-20000 -> 3 cycles; sum=0xD8F0, sf=1, cf=1, of=0, zf=0, id=1.
//   3. Add 40000+50000 (0x9C40+0xC350) -> sum=0x5F90, cf=1, of=1.
//      Sub 0x8000-0x0001 -> sum=0x7FFF, of=1, cf=0.
//      Sub 5-0 -> sum=5, all flags 0.
//   4. All three req_valid held high with adds -> grants in order 0,1,2,0,1.
//      Exactly one req_ready per grant; resp_id follows the same order.
//   5. rst_n low during NEG of a sub -> no resp_valid; next cycle state IDLE, req_ready, resp_valid and flags all 0.
//      First grant after reset goes to req0.
//   6. Back-to-back adds from req2 only, with the bench modelling adder16 at the add_a/add_b/add_s ports
//      -> resp_valid on every second cycle, never two consecutive cycles.

Source files
------------

// File: rtl/adder16_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : adder16_sched_if
// Description : Bundle between the requesters/adder16 side and the shared
//               adder scheduler. The master side is the control unit together
//               with the adder16 instance; the slave side is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder16_sched_if #(
  parameter int W    = 16,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_of;
  logic              resp_sf;
  logic              resp_zf;
  logic              resp_cf;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_s;

  modport master (
    output req_valid, req_sub, req_a, req_b, add_s,
    input  req_ready, resp_valid, resp_id, resp_sum,
    input  resp_of, resp_sf, resp_zf, resp_cf, add_a, add_b
  );

  modport slave (
    input  req_valid, req_sub, req_a, req_b, add_s,
    output req_ready, resp_valid, resp_id, resp_sum,
    output resp_of, resp_sf, resp_zf, resp_cf, add_a, add_b
  );
endinterface
`default_nettype wire

// File: rtl/adder16_sched.sv
`default_nettype none
// ============================================================================
// Module      : adder16_sched
// Description : Round-robin scheduler sharing one combinational 16-bit adder
//               between NREQ requesters. Subtraction takes two adder passes
//               (two's-complement negate of b, then add). Returns the sum with
//               OF/SF/ZF/CF flags as a one-cycle result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module adder16_sched #(
  parameter int W    = 16,
  parameter int NREQ = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  adder16_sched_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   id_q, id_d;
  logic         sub_q, sub_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] tmp_q, tmp_d;
  logic         resp_valid_q, resp_valid_d;
  logic [1:0]   resp_id_q, resp_id_d;
  logic [W-1:0] resp_sum_q, resp_sum_d;
  logic         resp_of_q, resp_of_d;
  logic         resp_sf_q, resp_sf_d;
  logic         resp_zf_q, resp_zf_d;
  logic         resp_cf_q, resp_cf_d;

  logic         found;
  logic [1:0]   grant_id;

  // Round-robin pick: first valid above the last winner, else first valid from 0 upward.
  always_comb begin
    found    = 1'b0;
    grant_id = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i] && (i > int'(last_q))) begin
        found    = 1'b1;
        grant_id = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[i] && (i <= int'(last_q))) begin
        found    = 1'b1;
        grant_id = 2'(i);
      end
    end
  end

  // Next-state, adder operand steering, capture and flag generation.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    sub_d         = sub_q;
    a_d           = a_q;
    b_d           = b_q;
    tmp_d         = tmp_q;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_sum_d    = resp_sum_q;
    resp_of_d     = resp_of_q;
    resp_sf_d     = resp_sf_q;
    resp_zf_d     = resp_zf_q;
    resp_cf_d     = resp_cf_q;
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          bus.req_ready[grant_id] = 1'b1;
          id_d    = grant_id;
          last_d  = grant_id;
          sub_d   = bus.req_sub[grant_id];
          a_d     = bus.req_a[int'(grant_id)*W +: W];
          b_d     = bus.req_b[int'(grant_id)*W +: W];
          state_d = bus.req_sub[grant_id] ? S_NEG : S_ADD;
        end
      end
      S_NEG: begin
        // First pass of a subtraction: tmp = -b.
        bus.add_a = ~b_q;
        bus.add_b = W'(1);
        tmp_d     = bus.add_s;
        state_d   = S_ADD;
      end
      S_ADD: begin
        bus.add_a    = a_q;
        bus.add_b    = sub_q ? tmp_q : b_q;
        resp_sum_d   = bus.add_s;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        resp_sf_d    = bus.add_s[W-1];
        resp_zf_d    = (bus.add_s == '0);
        // Flags are taken from the captured operands, never from tmp.
        if (sub_q) begin
          resp_cf_d = (a_q < b_q);
          resp_of_d = (a_q[W-1] != b_q[W-1]) && (bus.add_s[W-1] != a_q[W-1]);
        end else begin
          resp_cf_d = (bus.add_s < a_q);
          resp_of_d = (a_q[W-1] == b_q[W-1]) && (bus.add_s[W-1] != a_q[W-1]);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= 2'(NREQ-1);
      id_q         <= 2'd0;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      tmp_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 2'd0;
      resp_sum_q   <= '0;
      resp_of_q    <= 1'b0;
      resp_sf_q    <= 1'b0;
      resp_zf_q    <= 1'b0;
      resp_cf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      sub_q        <= sub_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tmp_q        <= tmp_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_of_q    <= resp_of_d;
      resp_sf_q    <= resp_sf_d;
      resp_zf_q    <= resp_zf_d;
      resp_cf_q    <= resp_cf_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_of    = resp_of_q;
  assign bus.resp_sf    = resp_sf_q;
  assign bus.resp_zf    = resp_zf_q;
  assign bus.resp_cf    = resp_cf_q;

endmodule
`default_nettype wire
